// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for a MIPS-subset datapath
// Define ILLEGAL_TRAP_EN to trap unknown instructions into HALT with an illegal output; otherwise they retire as NOPs.
module multicycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             stall,
    output logic             instr_wr,
    output logic             rs_wr,
    output logic             rt_wr,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic [2:0]       alu_cmd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             retire,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       dec_r_alu, dec_jr, dec_j, dec_jal, dec_br, dec_taken;
    logic       dec_imm_alu, dec_lw, dec_sw, dec_known;
    logic [2:0] dec_alu_cmd;
    logic       dec_alu_src;

    // Instruction classification; valid whenever opcode/funct hold the stored instruction.
    always_comb begin
        dec_r_alu   = 1'b0;
        dec_jr      = 1'b0;
        dec_j       = 1'b0;
        dec_jal     = 1'b0;
        dec_br      = 1'b0;
        dec_taken   = 1'b0;
        dec_imm_alu = 1'b0;
        dec_lw      = 1'b0;
        dec_sw      = 1'b0;
        dec_alu_cmd = ALU_ADD;
        dec_alu_src = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin dec_r_alu = 1'b1; dec_alu_cmd = ALU_ADD; end
                    FN_SUB:  begin dec_r_alu = 1'b1; dec_alu_cmd = ALU_SUB; end
                    FN_SLT:  begin dec_r_alu = 1'b1; dec_alu_cmd = ALU_SLT; end
                    FN_JR:   dec_jr = 1'b1;
                    default: ;
                endcase
            end
            OP_J:    dec_j   = 1'b1;
            OP_JAL:  dec_jal = 1'b1;
            OP_BEQ:  begin dec_br = 1'b1; dec_taken = zero;  dec_alu_cmd = ALU_SUB; end
            OP_BNE:  begin dec_br = 1'b1; dec_taken = ~zero; dec_alu_cmd = ALU_SUB; end
            OP_ADDI: begin dec_imm_alu = 1'b1; dec_alu_cmd = ALU_ADD; dec_alu_src = 1'b1; end
            OP_XORI: begin dec_imm_alu = 1'b1; dec_alu_cmd = ALU_XOR; dec_alu_src = 1'b1; end
            OP_LW:   begin dec_lw = 1'b1; dec_alu_src = 1'b1; end
            OP_SW:   begin dec_sw = 1'b1; dec_alu_src = 1'b1; end
            default: ;
        endcase
        dec_known = dec_r_alu | dec_jr | dec_j | dec_jal | dec_br |
                    dec_imm_alu | dec_lw | dec_sw;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = stall ? S_FETCH : S_DECODE;
            S_DECODE: begin
                if (dec_j || dec_jal) state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                else if (!dec_known)  state_d = S_HALT;
`endif
                else                  state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec_lw || dec_sw)                 state_d = S_MEM;
                else if (dec_r_alu || dec_imm_alu)    state_d = S_WB;
`ifdef ILLEGAL_TRAP_EN
                else if (!dec_known)                  state_d = S_HALT;
`endif
                else                                  state_d = S_FETCH;
            end
            S_MEM: begin
                if (stall)       state_d = S_MEM;
                else if (dec_lw) state_d = S_WB;
                else             state_d = S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, including the reset cycle itself.
    always_comb begin
        instr_wr   = 1'b0;
        rs_wr      = 1'b0;
        rt_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'd0;
        alu_src    = 1'b0;
        alu_cmd    = ALU_ADD;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        if (reset) begin
            case (state_q)
                S_FETCH: instr_wr = ~stall;
                S_DECODE: begin
                    rs_wr = 1'b1;
                    rt_wr = 1'b1;
                    if (dec_j || dec_jal) begin
                        pc_wr  = 1'b1;
                        pc_src = 2'd2;
                    end
                    if (dec_jal) begin
                        reg_wr     = 1'b1;
                        reg_dst    = 2'd1;
                        mem_to_reg = 2'd2;
                    end
                end
                S_EXEC: begin
                    alu_cmd = dec_alu_cmd;
                    alu_src = dec_alu_src;
                    if (dec_br) begin
                        pc_wr  = 1'b1;
                        pc_src = dec_taken ? 2'd1 : 2'd0;
                    end else if (dec_jr) begin
                        pc_wr  = 1'b1;
                        pc_src = 2'd3;
                    end
`ifndef ILLEGAL_TRAP_EN
                    else if (!dec_known) begin
                        pc_wr = 1'b1;
                    end
`endif
                end
                S_MEM: begin
                    alu_cmd = dec_alu_cmd;
                    alu_src = dec_alu_src;
                    if (dec_sw) begin
                        mem_wr = ~stall;
                        pc_wr  = ~stall;
                    end
                end
                S_WB: begin
                    alu_cmd    = dec_alu_cmd;
                    alu_src    = dec_alu_src;
                    reg_wr     = 1'b1;
                    pc_wr      = 1'b1;
                    reg_dst    = dec_r_alu ? 2'd0 : 2'd2;
                    mem_to_reg = dec_lw ? 2'd1 : 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign retire     = pc_wr;
    assign cnt_d      = pc_wr ? cnt_q + CNT_W'(1) : cnt_q;
    assign inst_count = reset ? cnt_q : '0;
`ifdef ILLEGAL_TRAP_EN
    assign illegal    = reset && (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized and directed bench for multicycle_sequencer against a per-instruction cycle model
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       instr_wr;
        logic       rs_wr;
        logic       rt_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [2:0] alu_cmd;
        logic       mem_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       retire;
    } outs_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode, funct;
    logic             zero, stall;
    logic             instr_wr, rs_wr, rt_wr, pc_wr, alu_src, mem_wr, reg_wr, retire;
    logic [1:0]       pc_src, reg_dst, mem_to_reg;
    logic [2:0]       alu_cmd;
    logic [CNT_W-1:0] inst_count;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal;
`endif
    outs_t            obs;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .stall(stall),
        .instr_wr(instr_wr), .rs_wr(rs_wr), .rt_wr(rt_wr), .pc_wr(pc_wr), .pc_src(pc_src),
        .alu_src(alu_src), .alu_cmd(alu_cmd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire),
`ifdef ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .inst_count(inst_count)
    );

    assign obs = {instr_wr, rs_wr, rt_wr, pc_wr, pc_src, alu_src, alu_cmd,
                  mem_wr, reg_wr, reg_dst, mem_to_reg, retire};

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;
    int    model_cnt = 0;
    outs_t exp_q[$];
    bit    stl_q[$];

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Expected per-cycle outputs of one instruction, derived from its class and the
    // cycle-by-cycle behaviour table; stl_q marks cycles where stall is honoured.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        outs_t o;
        logic [2:0] cmd;
        logic       src;
        string      kind;
        exp_q.delete();
        stl_q.delete();
        o = '0; o.instr_wr = 1'b1;
        exp_q.push_back(o); stl_q.push_back(1'b1);
        o = '0; o.rs_wr = 1'b1; o.rt_wr = 1'b1;
        if (op == 6'h02 || op == 6'h03) begin
            o.pc_wr = 1'b1; o.pc_src = 2'd2; o.retire = 1'b1;
            if (op == 6'h03) begin o.reg_wr = 1'b1; o.reg_dst = 2'd1; o.mem_to_reg = 2'd2; end
            exp_q.push_back(o); stl_q.push_back(1'b0);
            return;
        end
        exp_q.push_back(o); stl_q.push_back(1'b0);
        cmd = 3'd0; src = 1'b0; kind = "nop";
        case (op)
            6'h00: case (fn)
                6'h20: begin cmd = 3'd0; kind = "r"; end
                6'h22: begin cmd = 3'd1; kind = "r"; end
                6'h2A: begin cmd = 3'd3; kind = "r"; end
                6'h08: kind = "jr";
                default: kind = "nop";
            endcase
            6'h08: begin cmd = 3'd0; src = 1'b1; kind = "imm"; end
            6'h0E: begin cmd = 3'd2; src = 1'b1; kind = "imm"; end
            6'h23: begin src = 1'b1; kind = "lw"; end
            6'h2B: begin src = 1'b1; kind = "sw"; end
            6'h04: begin cmd = 3'd1; kind = z ? "taken" : "fall"; end
            6'h05: begin cmd = 3'd1; kind = z ? "fall" : "taken"; end
            default: kind = "nop";
        endcase
        o = '0; o.alu_cmd = cmd; o.alu_src = src;
        if (kind == "taken" || kind == "fall" || kind == "jr" || kind == "nop") begin
            o.pc_wr = 1'b1; o.retire = 1'b1;
            o.pc_src = (kind == "taken") ? 2'd1 : (kind == "jr") ? 2'd3 : 2'd0;
            exp_q.push_back(o); stl_q.push_back(1'b0);
            return;
        end
        exp_q.push_back(o); stl_q.push_back(1'b0);
        if (kind == "lw" || kind == "sw") begin
            o = '0; o.alu_cmd = cmd; o.alu_src = src;
            if (kind == "sw") begin o.mem_wr = 1'b1; o.pc_wr = 1'b1; o.retire = 1'b1; end
            exp_q.push_back(o); stl_q.push_back(1'b1);
            if (kind == "sw") return;
        end
        o = '0; o.alu_cmd = cmd; o.alu_src = src;
        o.reg_wr = 1'b1; o.pc_wr = 1'b1; o.retire = 1'b1;
        o.reg_dst = (kind == "r") ? 2'd0 : 2'd2;
        o.mem_to_reg = (kind == "lw") ? 2'd1 : 2'd0;
        exp_q.push_back(o); stl_q.push_back(1'b0);
    endtask

    // mode 0: random stall every cycle; 1: no stall; 2: stall exactly two cycles at step 3.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int mode, input int max_steps, input string tag);
        int    idx = 0;
        int    run = 0;
        int    forced = 0;
        logic  s;
        outs_t e;
        build(op, fn, z);
        opcode = op; funct = fn; zero = z;
        while (idx < exp_q.size() && idx < max_steps) begin
            if (mode == 0)      s = ($urandom_range(0, 2) == 0);
            else if (mode == 1) s = 1'b0;
            else                s = (idx == 3 && forced < 2);
            if (stl_q[idx] && run >= 3) s = 1'b0;
            if (s && idx == 3) forced++;
            stall = s;
            #1;
            e = exp_q[idx];
            if (s && stl_q[idx]) begin
                e.instr_wr = 1'b0; e.mem_wr = 1'b0; e.pc_wr = 1'b0;
                e.reg_wr = 1'b0; e.retire = 1'b0;
            end
            check($sformatf("%s step%0d outs", tag, idx), {15'd0, obs}, {15'd0, e});
            check($sformatf("%s step%0d cnt", tag, idx), {28'd0, inst_count}, model_cnt);
            if (e.retire) model_cnt = (model_cnt + 1) % (1 << CNT_W);
            if (s && stl_q[idx]) run++;
            else begin run = 0; idx++; end
            @(negedge clk);
        end
        stall = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input string tag);
        reset = 1'b0;
        stall = 1'b0;
        repeat (cycles) begin
            #1;
            check({tag, " outs"}, {15'd0, obs}, 32'd0);
            check({tag, " cnt"}, {28'd0, inst_count}, 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        model_cnt = 0;
    endtask

    logic [5:0] ops_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B,
                                 6'h04, 6'h05, 6'h02, 6'h03, 6'h00, 6'h3F, 6'h10, 6'h00};
    logic [5:0] fn_tab  [16] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h21, 6'h00, 6'h00, 6'h25};

    initial begin
        logic [5:0] fn;
        int         k;
        reset = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; stall = 1'b0;
        @(negedge clk);
        do_reset(2, "reset");

        run_instr(6'h00, 6'h20, 1'b0, 1, 99, "add");
        run_instr(6'h23, 6'h00, 1'b0, 2, 99, "lw_stall2");
        run_instr(6'h04, 6'h00, 1'b1, 1, 99, "beq_z1");
        run_instr(6'h05, 6'h00, 1'b1, 1, 99, "bne_z1");
        run_instr(6'h03, 6'h00, 1'b0, 1, 99, "jal");
        run_instr(6'h2B, 6'h00, 1'b0, 1, 99, "sw");
        run_instr(6'h00, 6'h08, 1'b0, 1, 99, "jr");
        run_instr(6'h0E, 6'h00, 1'b0, 1, 99, "xori");

`ifdef ILLEGAL_TRAP_EN
        run_instr(6'h3F, 6'h00, 1'b0, 1, 2, "ill_pre");
        repeat (3) begin
            #1;
            check("halt outs", {15'd0, obs}, 32'd0);
            check("halt illegal", {31'd0, illegal}, 32'd1);
            check("halt cnt", {28'd0, inst_count}, model_cnt);
            @(negedge clk);
        end
        do_reset(1, "halt_reset");
`else
        run_instr(6'h3F, 6'h00, 1'b0, 1, 99, "illegal_nop");
`endif

        run_instr(6'h23, 6'h00, 1'b0, 1, 3, "lw_abort");
        do_reset(1, "mid_lw_reset");

        for (int i = 0; i < 80; i++) begin
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(0, 11);
`else
            k = $urandom_range(0, 15);
`endif
            fn = (ops_tab[k] == 6'h00) ? fn_tab[k] : 6'($urandom_range(0, 63));
            run_instr(ops_tab[k], fn, 1'($urandom_range(0, 1)), 0, 99,
                      $sformatf("rand%0d op%0h", i, ops_tab[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
